// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_pkg
// Description : Shared router definitions. Holds the input-buffer sizing
//               defaults, the flit and pressure types, and the port indices
//               that the route-compute and allocator stages also use.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int DATASIZE = 40;  // flit width in bits
  localparam int DEPTH    = 8;   // input buffer entries (power of two)
  localparam int WIDTH    = 3;   // log2(DEPTH)

  typedef logic [DATASIZE-1:0] flit_t;
  typedef logic [WIDTH:0]      pressure_t;

  // Router port indices, one input buffer per port
  localparam logic [1:0] PORT_E = 2'd0;
  localparam logic [1:0] PORT_W = 2'd1;
  localparam logic [1:0] PORT_S = 2'd2;
  localparam logic [1:0] PORT_L = 2'd3;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/in_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : in_buffer_mem
// Description : DEPTH x DATASIZE register array for the router input buffer.
//               One synchronous write port, one combinational read port.
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module in_buffer_mem
  import noc_pkg::*;
#(
  parameter int DEPTH    = noc_pkg::DEPTH,
  parameter int WIDTH    = noc_pkg::WIDTH,
  parameter int DATASIZE = noc_pkg::DATASIZE
) (
  input  logic                clk,
  input  logic                we,
  input  logic [WIDTH-1:0]    waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [WIDTH-1:0]    raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [DEPTH];

  // Write the incoming flit into the addressed slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head-of-queue read is combinational so the FIFO falls through
  assign rdata = mem[raddr];

endmodule : in_buffer_mem
`default_nettype wire

// File: rtl/in_buffer.sv
`default_nettype none
// ============================================================================
// Module      : in_buffer
// Description : Per-port router input FIFO with first-word fall-through.
//               Presents the head flit to route compute and exports its
//               occupancy as a pressure value for neighbour adaptive routing.
//               Optional macro IN_BUFFER_OVF_CHK_EN enables the sticky
//               overflow_err flag (valid_in while full); otherwise it is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module in_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH    = noc_pkg::DEPTH,
  parameter int WIDTH    = noc_pkg::WIDTH,
  parameter int DATASIZE = noc_pkg::DATASIZE
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                overflow_err
);

  localparam logic [WIDTH:0] PTR_ONE = {{WIDTH{1'b0}}, 1'b1};

  // Pointers carry a wrap bit above the index so full and empty differ
  logic [WIDTH:0] wr_ptr;
  logic [WIDTH:0] rd_ptr;
  logic [WIDTH:0] count;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[WIDTH-1:0] == rd_ptr[WIDTH-1:0]) &&
                 (wr_ptr[WIDTH] != rd_ptr[WIDTH]);

  // Handshakes depend only on registered state, never on valid_in
  assign ready_out = !full;
  assign valid_out = !empty;
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && rc_ready;

  assign pressure_out = count;

  in_buffer_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) u_mem (
    .clk   (rc_clk),
    .we    (push),
    .waddr (wr_ptr[WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[WIDTH-1:0]),
    .rdata (data_out)
  );

  // Advance the write pointer on each accepted flit; power-of-two depth wraps naturally
  always_ff @(posedge rc_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Advance the read pointer when route compute takes the head flit
  always_ff @(posedge rc_clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy counter; push and pop together leave it unchanged
  always_ff @(posedge rc_clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + PTR_ONE;
    end else if (pop && !push) begin
      count <= count - PTR_ONE;
    end
  end

`ifdef IN_BUFFER_OVF_CHK_EN
  logic ovf_flag;

  // Latch any attempt to send while full; cleared only by reset
  always_ff @(posedge rc_clk) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
    end else if (valid_in && full) begin
      ovf_flag <= 1'b1;
    end
  end

  assign overflow_err = ovf_flag;
`else
  assign overflow_err = 1'b0;
`endif

endmodule : in_buffer
`default_nettype wire
